unsigned_solve_v: RTL
=====================

UNSIGNED_SOLVE_V -- requirements
Module: unsigned_solve_v

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; no other clocks or resets.
REQ-002 i_clk  input  1  clock; all state updates on the rising edge.
REQ-003 i_rst_n  input  1  asynchronous active-low reset.
REQ-004 i_start  input  1  request to solve; sampled only in IDLE.
REQ-005 i_fu  input  8  target value f, unsigned, the 8-bit result of the forward calculator.
REQ-006 i_bu  input  4  operand b, unsigned.
REQ-007 i_cu  input  4  operand c, unsigned.
REQ-008 o_au  output  4  recovered operand a, unsigned.
REQ-009 o_valid  output  1  high when o_au satisfies the equation.
REQ-010 o_busy  output  1  high while a solve is in progress (SEARCH or DONE).
REQ-011 o_done  output  1  one-cycle completion pulse.

Function
REQ-012 The block SHALL find a in 0..15 such that (7*a - 3*b + 6*c) mod 256 == f, which inverts the forward calculator f = 7a - 3b + 6c truncated to 8 bits.
REQ-013 All accumulator arithmetic SHALL be 8-bit modulo 256; negative intermediates wrap (for example, -45 becomes 211).
REQ-014 The FSM SHALL have the states IDLE, SEARCH and DONE.
REQ-015 In IDLE with i_start=1 at an edge, the block SHALL:
- capture i_fu, i_bu and i_cu into registers;
- set idx=0 and acc=(6*i_cu - 3*i_bu) mod 256;
- enter SEARCH.
REQ-016 At each SEARCH edge, if acc==f_reg the block SHALL enter DONE with o_au<=idx and o_valid<=1.
REQ-017 Otherwise, if idx==15 the block SHALL enter DONE with o_au<=0 and o_valid<=0 (no solution).
REQ-018 Otherwise the block SHALL increment idx by 1 and add 7 to acc (mod 256), staying in SEARCH.
REQ-019 The block SHALL hold o_done=1 for exactly the one cycle spent in DONE, then return to IDLE.
REQ-020 Latency: o_done SHALL rise k+1 cycles after the edge that sampled i_start when the solution is a=k; on no solution it SHALL rise 16 cycles after.
REQ-021 The solution SHALL be unique, since 7 is invertible mod 256; the first match is the only match.
REQ-022 o_busy SHALL be 1 in SEARCH and DONE, and 0 in IDLE.
REQ-023 i_start SHALL be ignored while o_busy=1; no queuing and no restart.
REQ-024 The block SHALL hold o_au and o_valid stable from DONE until the next accepted i_start.
REQ-025 On the next accepted i_start, the block SHALL clear o_valid to 0 on the accepting edge.
REQ-026 Input changes after the i_start sample SHALL have no effect on the current solve.
REQ-027 If i_start is held high continuously, the block SHALL start back-to-back solves, accepting a new start on the first IDLE edge after DONE.

Reset
REQ-028 When i_rst_n=0, the block SHALL asynchronously force state=IDLE, o_au=0, o_valid=0, o_busy=0, o_done=0, idx=0, acc=0 and clear the captured registers.
REQ-029 Reset asserted mid-SEARCH or in DONE SHALL abort the solve with no o_done pulse.
REQ-030 After reset release, the first rising edge with i_start=1 SHALL be accepted.

Verification
REQ-031 Solve case: f=47, b=2, c=3, start -> o_au=5, o_valid=1, o_done 6 cycles after the start edge.
REQ-032 Wrap case: f=211, b=15, c=0 -> o_au=0, o_valid=1, o_done 1 cycle after the start edge.
REQ-033 Maximum-latency case: f=195, b=0, c=15 -> o_au=15, o_valid=1, o_done 16 cycles after the start edge.
REQ-034 No-solution case: f=1, b=0, c=0 (true a=183) -> o_au=0, o_valid=0, o_done 16 cycles after the start edge.
REQ-035 Busy and reset case:
- pulse i_start again 3 cycles into a solve -> ignored; result matches the first request;
- assert i_rst_n=0 mid-SEARCH -> all outputs 0 immediately, and no o_done appears.
REQ-036 Exhaustive sweep: all 4096 (a,b,c) inputs, forward-computed f -> o_au==a and o_valid=1 in every case.

Source files
------------

// File: rtl/unsigned_solve_v.sv
// Inverse of the forward calculator f = 7a - 3b + 6c (mod 256): sequentially searches
// a = 0..15, stepping the accumulator by 7 per candidate, and reports the unique match.
module unsigned_solve_v (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic [7:0] i_fu,
   input  logic [3:0] i_bu,
   input  logic [3:0] i_cu,
   output logic [3:0] o_au,
   output logic       o_valid,
   output logic       o_busy,
   output logic       o_done
);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StSearch = 2'd1,
      StDone   = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] f_q, f_d;
   logic [3:0] idx_q, idx_d;
   logic [7:0] acc_q, acc_d;
   logic [3:0] au_q, au_d;
   logic       valid_q, valid_d;

   logic [7:0] b_ext;
   logic [7:0] c_ext;
   logic [7:0] acc_init;

   // b and c only enter through the seed accumulator, so it is the captured form of both.
   always_comb begin
      b_ext    = {4'b0000, i_bu};
      c_ext    = {4'b0000, i_cu};
      acc_init = (c_ext << 2) + (c_ext << 1) - ((b_ext << 1) + b_ext);
   end

   always_comb begin
      state_d = state_q;
      f_d     = f_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      au_d    = au_q;
      valid_d = valid_q;

      case (state_q)
         StIdle: begin
            if (i_start) begin
               f_d     = i_fu;
               idx_d   = 4'd0;
               acc_d   = acc_init;
               valid_d = 1'b0;
               state_d = StSearch;
            end
         end
         StSearch: begin
            if (acc_q == f_q) begin
               au_d    = idx_q;
               valid_d = 1'b1;
               state_d = StDone;
            end else if (idx_q == 4'd15) begin
               au_d    = 4'd0;
               valid_d = 1'b0;
               state_d = StDone;
            end else begin
               idx_d = idx_q + 4'd1;
               acc_d = acc_q + 8'd7;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         f_q     <= 8'd0;
         idx_q   <= 4'd0;
         acc_q   <= 8'd0;
         au_q    <= 4'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         f_q     <= f_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         au_q    <= au_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      o_au    = au_q;
      o_valid = valid_q;
      o_busy  = (state_q != StIdle);
      o_done  = (state_q == StDone);
   end

endmodule
